memory_tester: RTL and testbench
================================

MEMORY_TESTER -- requirements
Module: memory_tester

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 32, number of words tested.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum cycles valid may wait for ready.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port res, input, 1, reset (synchronous, active-high).
REQ-007 SHALL have port start, input, 1, begin test when idle or done.
REQ-008 SHALL have port seed, input, WIDTH, pattern seed, latched on accepted start.
REQ-009 SHALL have port valid, output, 1, transfer request to memory.
REQ-010 SHALL have port wr_rd, output, 1, 1 = write, 0 = read.
REQ-011 SHALL have port addr, output, ADDR_WIDTH, transfer address.
REQ-012 SHALL have port wdata, output, WIDTH, write data.
REQ-013 SHALL have port rdata, input, WIDTH, read data; valid only in a cycle where ready=1.
REQ-014 SHALL have port ready, input, 1, memory completion strobe.
REQ-015 SHALL have port busy, output, 1, test in progress.
REQ-016 SHALL have port done, output, 1, test finished (held).
REQ-017 SHALL have port pass, output, 1, finished with no mismatch and no timeout.
REQ-018 SHALL have port timeout, output, 1, test aborted on ready timeout.
REQ-019 SHALL have port err_count, output, ADDR_WIDTH+1, read mismatch count.
REQ-020 SHALL have port first_err_addr, output, ADDR_WIDTH, address of first mismatch.

Function
REQ-021 SHALL implement FSM states IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
REQ-022 SHALL, in IDLE or DONE, accept start=1: latch seed, clear done/pass/timeout/err_count/first_err_addr, set addr=0, go to WR_REQ next cycle.
REQ-023 SHALL ignore start in any other state.
REQ-024 SHALL, in WR_REQ, drive valid=1, wr_rd=1, wdata=addr[WIDTH-1:0 zero-extended] XOR seed_latched, and hold all three stable until ready=1 is sampled.
REQ-025 SHALL treat a rising edge with valid=1 and ready=1 as a completed transfer, then deassert valid for exactly one cycle (WR_GAP/RD_GAP) before the next request.
REQ-026 SHALL, after the write at addr DEPTH-1 completes, reset addr to 0 and proceed through WR_GAP to RD_REQ.
REQ-027 SHALL, in RD_REQ, drive valid=1, wr_rd=0, wdata=0, hold addr until ready=1.
REQ-028 SHALL, on read completion, compare rdata to addr XOR seed_latched; on mismatch, increment err_count (saturating at all-ones) and capture first_err_addr if err_count was 0.
REQ-029 SHALL, after the read at addr DEPTH-1 completes, go to DONE: done=1, busy=0, valid=0, pass=(err_count==0 including the final compare).
REQ-030 SHALL keep a wait counter, cleared on each new request; if valid has been high TIMEOUT cycles without ready, go to DONE with timeout=1, pass=0, valid=0.
REQ-031 SHALL assert busy in all states except IDLE and DONE.
REQ-032 SHALL ignore ready whenever valid=0.
REQ-033 SHALL keep addr within 0..DEPTH-1 with no wrap beyond DEPTH-1.

Reset
REQ-034 SHALL, with res=1 at a rising edge, enter IDLE with valid=0, wr_rd=0, addr=0, wdata=0, busy=0, done=0, pass=0, timeout=0, err_count=0, first_err_addr=0.
REQ-035 SHALL abort any transfer in progress on reset, with valid=0 from the next cycle, and SHALL ignore start while res=1.

Verification
REQ-036 SHALL test the ideal memory case: seed=8'hA5, ready one cycle after valid -> 32 writes (addr 5: wdata=8'hA0), 32 reads; done=1, pass=1, err_count=0.
REQ-037 SHALL test a single fault: the model flips rdata[0] at addr 5 -> err_count=1, first_err_addr=5, pass=0, done=1.
REQ-038 SHALL test the timeout case: ready tied 0 -> valid high 16 cycles at addr 0, then timeout=1, done=1, pass=0, valid=0.
REQ-039 SHALL test reset mid-write: res=1 while addr=10 in WR_REQ -> next cycle valid=0, busy=0, addr=0, FSM in IDLE.
REQ-040 SHALL test start during the test: start pulsed during the read phase -> no effect, err_count and addr sequence unchanged; start in DONE restarts with flags cleared.
REQ-041 SHALL test handshake stability: random ready latency 0-5 cycles -> addr, wdata and wr_rd constant while valid=1 and ready=0, exactly one gap cycle after each transfer.

Source files
------------

// File: rtl/memory_tester.sv
// memory_tester
//   Write-then-read pattern tester for a simple valid/ready memory port.
//   Every word 0..DEPTH-1 is written with (addr XOR seed), then read back
//   and compared. Mismatches are counted and the first failing address is
//   kept. A request left unanswered for TIMEOUT cycles aborts the test.
//
// Ports
//   clk            : single clock, all state changes on the rising edge
//   res            : synchronous active-high reset
//   start          : begin a test (accepted only in IDLE or DONE)
//   seed           : pattern seed, latched when start is accepted
//   valid          : transfer request towards the memory
//   wr_rd          : 1 = write, 0 = read
//   addr           : transfer address
//   wdata          : write data (0 during reads)
//   rdata          : read data, meaningful only while ready=1
//   ready          : memory completion strobe
//   busy           : test in progress
//   done           : test finished (held until the next start or reset)
//   pass           : finished with no mismatch and no timeout
//   timeout        : test aborted because ready never arrived
//   err_count      : saturating read mismatch count
//   first_err_addr : address of the first read mismatch
module memory_tester #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int CMN_W  = (WIDTH < ADDR_WIDTH) ? WIDTH : ADDR_WIDTH;
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ERR_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_GAP,
    RD_REQ,
    RD_GAP,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  valid_q, valid_d;
  logic                  wr_rd_q, wr_rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [ADDR_WIDTH:0]   err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  mismatch;

  // Expected word for an address: the address zero-extended (or truncated)
  // to the data width, XORed with the seed.
  function automatic logic [WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                               input logic [WIDTH-1:0]      s);
    logic [WIDTH-1:0] p;
    p = s;
    p[CMN_W-1:0] = s[CMN_W-1:0] ^ a[CMN_W-1:0];
    return p;
  endfunction

  // Next-state logic. Every output is a flop, so each transition computes
  // the values the outputs must show during the following cycle. A request
  // state only reacts to ready; ready in the gap/idle states is ignored
  // because those states never look at it.
  always_comb begin
    state_d          = state_q;
    seed_d           = seed_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    valid_d          = valid_q;
    wr_rd_d          = wr_rd_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    timeout_d        = timeout_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    wait_d           = wait_q;
    mismatch         = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d          = WR_REQ;
          seed_d           = seed;
          addr_d           = '0;
          wdata_d          = pattern('0, seed);
          valid_d          = 1'b1;
          wr_rd_d          = 1'b1;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          timeout_d        = 1'b0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          wait_d           = '0;
        end
      end

      WR_REQ, RD_REQ: begin
        if (ready) begin
          valid_d = 1'b0;
          wait_d  = '0;
          if (state_q == RD_REQ) begin
            mismatch = (rdata != pattern(addr_q, seed_q));
            if (mismatch) begin
              if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + 1'b1;
              end
              if (err_count_q == '0) begin
                first_err_addr_d = addr_q;
              end
            end
          end
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            if (state_q == WR_REQ) begin
              state_d = WR_GAP;
            end else begin
              // The final compare is folded into pass here.
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_count_q == '0) && !mismatch;
              wr_rd_d = 1'b0;
              wdata_d = '0;
            end
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = (state_q == WR_REQ) ? WR_GAP : RD_GAP;
          end
        end else if (wait_q == WAIT_LAST) begin
          // Address is left at the stuck location for diagnosis.
          state_d   = DONE;
          valid_d   = 1'b0;
          wr_rd_d   = 1'b0;
          wdata_d   = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      // Address wrapped to 0 only after the last write, so that is the
      // signal to switch over to the read phase.
      WR_GAP: begin
        valid_d = 1'b1;
        wait_d  = '0;
        if (addr_q == '0) begin
          state_d = RD_REQ;
          wr_rd_d = 1'b0;
          wdata_d = '0;
        end else begin
          state_d = WR_REQ;
          wr_rd_d = 1'b1;
          wdata_d = pattern(addr_q, seed_q);
        end
      end

      RD_GAP: begin
        state_d = RD_REQ;
        valid_d = 1'b1;
        wr_rd_d = 1'b0;
        wdata_d = '0;
        wait_d  = '0;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset wins over everything, including a
  // start seen in the same cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q          <= IDLE;
      seed_q           <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      valid_q          <= 1'b0;
      wr_rd_q          <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      timeout_q        <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      wait_q           <= '0;
    end else begin
      state_q          <= state_d;
      seed_q           <= seed_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      valid_q          <= valid_d;
      wr_rd_q          <= wr_rd_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      timeout_q        <= timeout_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      wait_q           <= wait_d;
    end
  end

  assign valid          = valid_q;
  assign wr_rd          = wr_rd_q;
  assign addr           = addr_q;
  assign wdata          = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_memory_tester.sv
// tb_memory_tester
//   Table-driven bench for memory_tester. A behavioural memory answers
//   requests with a fixed or random latency (or never), can flip rdata[0]
//   at chosen addresses, and watches the handshake. Each table row is one
//   full test run; hand-written sequences cover timeout length, reset in
//   the middle of a write, and start pulses while busy / after done.
module tb_memory_tester;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          res;
  logic          start;
  logic [7:0]    seed;
  logic          valid;
  logic          wr_rd;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic          ready;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  int vec_count  = 0;
  int miss_count = 0;

  logic [7:0]  mem [DEPTH];
  logic [31:0] fault_mask = '0;
  bit          rand_lat   = 1'b0;
  bit          tie_low    = 1'b0;
  int          hs_viol    = 0;
  int          xfer_idx   = 0;

  memory_tester #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .res(res),
    .start(start),
    .seed(seed),
    .valid(valid),
    .wr_rd(wr_rd),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // Memory model and protocol watcher, active on the falling edge. It first
  // judges what happened at the preceding rising edge (held request stayed
  // stable, completed transfer was the expected address/direction, exactly
  // one idle cycle follows each transfer), then decides ready/rdata for the
  // next rising edge.
  initial begin
    int         cnt;
    int         lat;
    int         exp_addr;
    bit         exp_wr;
    bit         p_valid;
    bit         p_ready;
    bit         p_wr_rd;
    bit         p_busy;
    bit         gap_pending;
    logic [AW-1:0] p_addr;
    logic [7:0] p_wdata;
    cnt = 0; lat = 1;
    p_valid = 0; p_ready = 0; p_wr_rd = 0; p_busy = 0; gap_pending = 0;
    p_addr = '0; p_wdata = '0;
    ready = 1'b0;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (res) begin
        gap_pending = 0;
        ready       = 1'b0;
      end else begin
        if (!p_busy && busy === 1'b1) xfer_idx = 0;
        if (p_valid && !p_ready && done !== 1'b1) begin
          if (valid !== 1'b1 || addr !== p_addr || wdata !== p_wdata || wr_rd !== p_wr_rd)
            hs_viol++;
        end
        if (p_valid && p_ready) begin
          exp_addr = xfer_idx % DEPTH;
          exp_wr   = (xfer_idx < DEPTH);
          if (int'(p_addr) != exp_addr || p_wr_rd != exp_wr) hs_viol++;
          if (valid !== 1'b0) hs_viol++;
          xfer_idx++;
          gap_pending = 1;
        end else if (gap_pending) begin
          if (done !== 1'b1 && valid !== 1'b1) hs_viol++;
          gap_pending = 0;
        end
        ready = 1'b0;
        rdata = 8'($urandom);
        if (valid === 1'b1 && !tie_low) begin
          if (!p_valid) begin
            cnt = 0;
            lat = rand_lat ? int'($urandom_range(0, 5)) : 1;
          end
          if (cnt >= lat) begin
            ready = 1'b1;
            if (wr_rd) mem[addr] = wdata;
            else       rdata = mem[addr] ^ {7'b0, fault_mask[addr]};
          end else begin
            cnt++;
          end
        end
      end
      p_valid = (valid === 1'b1);
      p_ready = ready;
      p_addr  = addr;
      p_wdata = wdata;
      p_wr_rd = (wr_rd === 1'b1);
      p_busy  = (busy === 1'b1);
    end
  end

  typedef struct {
    logic [7:0]  seed;
    logic [31:0] mask;
    bit          rnd;
    bit          tie;
    bit          e_done;
    bit          e_pass;
    bit          e_to;
    logic [5:0]  e_err;
    logic [4:0]  e_first;
    int          e_xfers;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    res   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    res   = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic pulseStart(input logic [7:0] s);
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    // One more cycle lets the watcher account for the final transfer.
    @(posedge clk); #1;
  endtask

  task automatic checkMemImage(input string name, input logic [7:0] s);
    int bad;
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] !== (8'(a) ^ s)) bad++;
    end
    checkOutput(name, bad, 0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int viol0;
    bit ok;
    fault_mask = v.mask;
    rand_lat   = v.rnd;
    tie_low    = v.tie;
    doReset();
    viol0 = hs_viol;
    pulseStart(v.seed);
    waitDone(ok);
    checkOutput($sformatf("v%0d finished", idx), ok, 1);
    checkOutput($sformatf("v%0d done", idx), done, v.e_done);
    checkOutput($sformatf("v%0d pass", idx), pass, v.e_pass);
    checkOutput($sformatf("v%0d timeout", idx), timeout, v.e_to);
    checkOutput($sformatf("v%0d err_count", idx), err_count, v.e_err);
    checkOutput($sformatf("v%0d first_err_addr", idx), first_err_addr, v.e_first);
    checkOutput($sformatf("v%0d valid_low", idx), valid, 0);
    checkOutput($sformatf("v%0d busy_low", idx), busy, 0);
    checkOutput($sformatf("v%0d transfers", idx), xfer_idx, v.e_xfers);
    checkOutput($sformatf("v%0d handshake", idx), hs_viol - viol0, 0);
    if (v.e_xfers == 2 * DEPTH) checkMemImage($sformatf("v%0d mem_image", idx), v.seed);
  endtask

  initial begin
    int  hi;
    int  viol0;
    bit  found;
    bit  ok;
    bit  addr_moved;

    res   = 1'b1;
    start = 1'b0;
    seed  = '0;

    vecs[0] = '{8'hA5, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  5'd0,  64};
    vecs[1] = '{8'hA5, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1,  5'd5,  64};
    vecs[2] = '{8'h3C, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1,  5'd31, 64};
    vecs[3] = '{8'h00, 32'h0010_0088, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd3,  5'd3,  64};
    vecs[4] = '{8'hFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd32, 5'd0,  64};
    vecs[5] = '{8'h5A, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  5'd0,  64};
    vecs[6] = '{8'hA5, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd0,  5'd0,  0};

    // Reset state
    doReset();
    checkOutput("rst valid", valid, 0);
    checkOutput("rst wr_rd", wr_rd, 0);
    checkOutput("rst addr", addr, 0);
    checkOutput("rst wdata", wdata, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst pass", pass, 0);
    checkOutput("rst timeout", timeout, 0);
    checkOutput("rst err_count", err_count, 0);
    checkOutput("rst first_err_addr", first_err_addr, 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], i);
      if (i == 0) checkOutput("v0 mem[5]", mem[5], 8'hA0);
    end

    // Timeout: valid must stay high exactly 16 cycles at address 0.
    fault_mask = '0; rand_lat = 1'b0; tie_low = 1'b1;
    doReset();
    pulseStart(8'h77);
    hi = 0; addr_moved = 1'b0;
    for (int i = 0; i < 100 && valid === 1'b1; i++) begin
      hi++;
      if (addr !== '0) addr_moved = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("to valid_cycles", hi, 16);
    checkOutput("to addr_held", addr_moved, 0);
    checkOutput("to timeout", timeout, 1);
    checkOutput("to done", done, 1);
    checkOutput("to pass", pass, 0);
    checkOutput("to valid", valid, 0);

    // Reset while writing address 10; start held high during reset.
    tie_low = 1'b0;
    doReset();
    pulseStart(8'h11);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (valid === 1'b1 && wr_rd === 1'b1 && addr === 5'd10) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("rmw reached addr10", found, 1);
    res = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    checkOutput("rmw valid", valid, 0);
    checkOutput("rmw busy", busy, 0);
    checkOutput("rmw addr", addr, 0);
    checkOutput("rmw done", done, 0);
    checkOutput("rmw wr_rd", wr_rd, 0);
    @(posedge clk); #1;
    checkOutput("rmw start_ignored_in_reset", busy, 0);
    res = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checkOutput("rmw idle_after_release", busy, 0);

    // Start pulse during the read phase must be ignored.
    fault_mask = 32'h0000_0020;
    doReset();
    viol0 = hs_viol;
    pulseStart(8'hA5);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (valid === 1'b1 && wr_rd === 1'b0 && addr === 5'd12) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("sdr reached read12", found, 1);
    pulseStart(8'h00);
    checkOutput("sdr busy", busy, 1);
    waitDone(ok);
    checkOutput("sdr finished", ok, 1);
    checkOutput("sdr err_count", err_count, 1);
    checkOutput("sdr first_err_addr", first_err_addr, 5);
    checkOutput("sdr pass", pass, 0);
    checkOutput("sdr transfers", xfer_idx, 64);
    checkOutput("sdr handshake", hs_viol - viol0, 0);

    // Restart from DONE clears the flags and runs a clean test.
    fault_mask = '0;
    viol0 = hs_viol;
    pulseStart(8'h5A);
    checkOutput("rs done_cleared", done, 0);
    checkOutput("rs pass_cleared", pass, 0);
    checkOutput("rs err_cleared", err_count, 0);
    checkOutput("rs first_cleared", first_err_addr, 0);
    checkOutput("rs timeout_cleared", timeout, 0);
    checkOutput("rs busy", busy, 1);
    checkOutput("rs valid", valid, 1);
    checkOutput("rs wdata0", wdata, 8'h5A);
    waitDone(ok);
    checkOutput("rs finished", ok, 1);
    checkOutput("rs pass", pass, 1);
    checkOutput("rs err_count", err_count, 0);
    checkOutput("rs handshake", hs_viol - viol0, 0);
    checkMemImage("rs mem_image", 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
